sram_access_arbiter: RTL and testbench

- Shares the single 16-bit asynchronous SRAM between two requesters: port 0 (CPU memory control unit) and port 1 (program loader / debug port).
- Arbitrates between pending requests and sequences the SRAM strobes (CE/OE/WE/LB/UB) with a programmable wait-state count.
- Captures read data and signals completion with a one-cycle done pulse. Sits between the memory control unit and the SRAM pins in the eLC-3 toplevel.

---
 rtl/elc3_mem_pkg.sv | 23 ++
 rtl/sram_grant_arbiter.sv | 52 +++++
 rtl/sram_access_arbiter.sv | 140 ++++++++++++++
 tb/tb_sram_access_arbiter.sv | 406 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/elc3_mem_pkg.sv
// Shared types and constants for the eLC-3 SRAM access path.
// ARB_ROUND_ROBIN_EN selects round-robin arbitration in sram_grant_arbiter.
package elc3_mem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        HOLD
    } arb_state_e;

    typedef logic grant_t;

    localparam int SRAM_DATA_W     = 16;
    localparam int WAIT_CYCLES_MIN = 1;
    localparam int WAIT_CYCLES_MAX = 15;
    localparam int WAIT_CNT_W      = 4;

    function automatic bit waitCyclesLegal(input int waitCycles);
        return (waitCycles >= WAIT_CYCLES_MIN) && (waitCycles <= WAIT_CYCLES_MAX);
    endfunction

endpackage

// File: rtl/sram_grant_arbiter.sv
// Picks which requester owns the next SRAM transaction.
// Fixed priority to port 0 by default; ARB_ROUND_ROBIN_EN adds a preferred-port pointer.
module sram_grant_arbiter
    import elc3_mem_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   valid0_i,
    input  logic   valid1_i,
    input  logic   grant_i,
    output logic   anyValid_o,
    output grant_t winner_o
);

    assign anyValid_o = valid0_i | valid1_i;

`ifdef ARB_ROUND_ROBIN_EN
    grant_t ptr_q;
    grant_t ptr_d;

    always_comb begin
        winner_o = 1'b0;
        if (valid0_i && valid1_i) begin
            winner_o = ptr_q;
        end else if (valid1_i) begin
            winner_o = 1'b1;
        end
    end

    // The port that just won loses preference for the next contested grant.
    always_comb begin
        ptr_d = ptr_q;
        if (grant_i) begin
            ptr_d = ~winner_o;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`else
    logic unused_rr;

    assign winner_o  = ~valid0_i & valid1_i;
    assign unused_rr = ^{clk, rst, grant_i};
`endif

endmodule

// File: rtl/sram_access_arbiter.sv
// Two-port arbiter and strobe sequencer for the eLC-3 asynchronous 16-bit SRAM.
// Define ARB_ROUND_ROBIN_EN for round-robin instead of fixed port-0 priority.
module sram_access_arbiter
    import elc3_mem_pkg::*;
#(
    parameter int WAIT_CYCLES = 2,
    parameter int ADDR_W      = 20
) (
    input  logic                   Clk,
    input  logic                   Reset,
    input  logic                   req0_valid,
    input  logic                   req0_we,
    input  logic [ADDR_W-1:0]      req0_addr,
    input  logic [SRAM_DATA_W-1:0] req0_wdata,
    output logic                   req0_done,
    input  logic                   req1_valid,
    input  logic                   req1_we,
    input  logic [ADDR_W-1:0]      req1_addr,
    input  logic [SRAM_DATA_W-1:0] req1_wdata,
    output logic                   req1_done,
    output logic [SRAM_DATA_W-1:0] rdata,
    output logic                   SRAM_CE_N,
    output logic                   SRAM_OE_N,
    output logic                   SRAM_WE_N,
    output logic                   SRAM_LB_N,
    output logic                   SRAM_UB_N,
    output logic [ADDR_W-1:0]      SRAM_ADDR,
    output logic [SRAM_DATA_W-1:0] dq_out,
    output logic                   dq_oe,
    input  logic [SRAM_DATA_W-1:0] dq_in
);

    if (!waitCyclesLegal(WAIT_CYCLES)) begin : g_bad_wait
        $error("sram_access_arbiter: WAIT_CYCLES must be within 1..15");
    end

    localparam logic [WAIT_CNT_W-1:0] CNT_LAST = WAIT_CNT_W'(WAIT_CYCLES - 1);
    localparam logic [WAIT_CNT_W-1:0] CNT_ONE  = WAIT_CNT_W'(1);

    arb_state_e             state_q, state_d;
    logic [WAIT_CNT_W-1:0]  cnt_q, cnt_d;
    grant_t                 grant_q, grant_d;
    logic                   we_q, we_d;
    logic [ADDR_W-1:0]      addr_q, addr_d;
    logic [SRAM_DATA_W-1:0] wdata_q, wdata_d;
    logic [SRAM_DATA_W-1:0] rdata_q, rdata_d;

    logic   anyValid;
    grant_t winner;
    logic   grantFire;

    assign grantFire = (state_q == IDLE) && anyValid;

    sram_grant_arbiter u_grant (
        .clk        (Clk),
        .rst        (Reset),
        .valid0_i   (req0_valid),
        .valid1_i   (req1_valid),
        .grant_i    (grantFire),
        .anyValid_o (anyValid),
        .winner_o   (winner)
    );

    // Request fields are captured once at grant; the requester may change them afterwards.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        grant_d = grant_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        case (state_q)
            IDLE: begin
                if (anyValid) begin
                    grant_d = winner;
                    we_d    = winner ? req1_we    : req0_we;
                    addr_d  = winner ? req1_addr  : req0_addr;
                    wdata_d = winner ? req1_wdata : req0_wdata;
                    cnt_d   = '0;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                state_d = ACCESS;
            end
            ACCESS: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = HOLD;
                    if (!we_q) begin
                        rdata_d = dq_in;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            HOLD: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            grant_q <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            grant_q <= grant_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    // Strobes decode straight from the state register so reset releases them without a clock.
    assign SRAM_CE_N = (state_q == IDLE);
    assign SRAM_LB_N = (state_q == IDLE);
    assign SRAM_UB_N = (state_q == IDLE);
    assign SRAM_OE_N = !((state_q == ACCESS) && !we_q);
    assign SRAM_WE_N = !((state_q == ACCESS) && we_q);
    assign dq_oe     = (state_q != IDLE) && we_q;
    assign req0_done = (state_q == HOLD) && (grant_q == 1'b0);
    assign req1_done = (state_q == HOLD) && (grant_q == 1'b1);
    assign SRAM_ADDR = addr_q;
    assign dq_out    = wdata_q;
    assign rdata     = rdata_q;

endmodule

// File: tb/tb_sram_access_arbiter.sv
// Self-checking bench for sram_access_arbiter with an SRAM model and completion scoreboard.
// Honours ARB_ROUND_ROBIN_EN for the contention expectations.
module tb_sram_access_arbiter #(
    parameter int WAIT_CYCLES = 2
);

    localparam int ADDR_W = 20;
    localparam int W      = WAIT_CYCLES;

    typedef struct {
        int          port;
        bit          we;
        logic [19:0] addr;
        logic [15:0] data;
    } exp_t;

    logic        Clk;
    logic        Reset;
    logic        req0_valid, req0_we, req0_done;
    logic [19:0] req0_addr;
    logic [15:0] req0_wdata;
    logic        req1_valid, req1_we, req1_done;
    logic [19:0] req1_addr;
    logic [15:0] req1_wdata;
    logic [15:0] rdata;
    logic        SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_LB_N, SRAM_UB_N;
    logic [19:0] SRAM_ADDR;
    logic [15:0] dq_out;
    logic        dq_oe;
    logic [15:0] dq_in;

    int testsRun    = 0;
    int testsFailed = 0;

    exp_t        sbQ[$];
    logic [15:0] mem [logic [19:0]];

    sram_access_arbiter #(
        .WAIT_CYCLES (WAIT_CYCLES),
        .ADDR_W      (ADDR_W)
    ) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .req0_valid (req0_valid),
        .req0_we    (req0_we),
        .req0_addr  (req0_addr),
        .req0_wdata (req0_wdata),
        .req0_done  (req0_done),
        .req1_valid (req1_valid),
        .req1_we    (req1_we),
        .req1_addr  (req1_addr),
        .req1_wdata (req1_wdata),
        .req1_done  (req1_done),
        .rdata      (rdata),
        .SRAM_CE_N  (SRAM_CE_N),
        .SRAM_OE_N  (SRAM_OE_N),
        .SRAM_WE_N  (SRAM_WE_N),
        .SRAM_LB_N  (SRAM_LB_N),
        .SRAM_UB_N  (SRAM_UB_N),
        .SRAM_ADDR  (SRAM_ADDR),
        .dq_out     (dq_out),
        .dq_oe      (dq_oe),
        .dq_in      (dq_in)
    );

    initial Clk = 1'b0;
    always #10 Clk = ~Clk;

    function automatic logic [15:0] memRead(input logic [19:0] a);
        return mem.exists(a) ? mem[a] : 16'h0000;
    endfunction

    // SRAM model: writes commit on edges where WE_N is low, reads present data mid-cycle.
    always @(posedge Clk) begin
        if (!SRAM_CE_N && !SRAM_WE_N && dq_oe) mem[SRAM_ADDR] = dq_out;
    end

    always @(negedge Clk) begin
        dq_in = (!SRAM_CE_N && !SRAM_OE_N) ? memRead(SRAM_ADDR) : 16'h0000;
    end

    // Scoreboard and strobe-safety monitor.
    always @(negedge Clk) begin
        exp_t e;
        int   who;
        testsRun++;
        if (!SRAM_WE_N && !SRAM_OE_N) begin
            testsFailed++;
            $display("[TB] FAIL we_oe_overlap got WE_N=%b OE_N=%b expected not both 0", SRAM_WE_N, SRAM_OE_N);
        end
        testsRun++;
        if (dq_oe && !SRAM_OE_N) begin
            testsFailed++;
            $display("[TB] FAIL dq_oe_with_oe got dq_oe=1 OE_N=0 expected no overlap");
        end
        if (!Reset && (req0_done || req1_done)) begin
            testsRun++;
            if (req0_done && req1_done) begin
                testsFailed++;
                $display("[TB] FAIL dual_done got both done expected one");
            end
            testsRun++;
            if (sbQ.size() == 0) begin
                testsFailed++;
                $display("[TB] FAIL unexpected_done got done0=%b done1=%b expected none", req0_done, req1_done);
            end else begin
                e   = sbQ.pop_front();
                who = req1_done ? 1 : 0;
                testsRun++;
                if (who != e.port) begin
                    testsFailed++;
                    $display("[TB] FAIL sb_port got %0d expected %0d", who, e.port);
                end
                testsRun++;
                if (e.we && memRead(e.addr) !== e.data) begin
                    testsFailed++;
                    $display("[TB] FAIL sb_mem got %h expected %h", memRead(e.addr), e.data);
                end else if (!e.we && rdata !== e.data) begin
                    testsFailed++;
                    $display("[TB] FAIL sb_rdata got %h expected %h", rdata, e.data);
                end
            end
        end
    end

    task automatic dropValid(input int port);
        if (port == 0) req0_valid = 1'b0;
        else           req1_valid = 1'b0;
    endtask

    task automatic issue(input int port, input bit we, input logic [19:0] addr,
                         input logic [15:0] data, input bit push);
        exp_t e;
        @(posedge Clk); #1;
        if (port == 0) begin
            req0_we = we; req0_addr = addr; req0_wdata = data; req0_valid = 1'b1;
        end else begin
            req1_we = we; req1_addr = addr; req1_wdata = data; req1_valid = 1'b1;
        end
        if (push) begin
            e.port = port; e.we = we; e.addr = addr;
            e.data = we ? data : memRead(addr);
            sbQ.push_back(e);
        end
    endtask

    // port 2 waits on either port; dropAt -1 drops valid at done, -2 never drops.
    task automatic waitDone(input int port, input int dropAt, output int k, output int who,
                            output logic [31:0] ceT, output logic [31:0] oeT,
                            output logic [31:0] weT, output logic [31:0] dqT);
        k = -1; who = -1; ceT = '0; oeT = '0; weT = '0; dqT = '0;
        for (int c = 0; c < 32; c++) begin
            @(negedge Clk);
            ceT[c] = ~SRAM_CE_N; oeT[c] = ~SRAM_OE_N; weT[c] = ~SRAM_WE_N; dqT[c] = dq_oe;
            if (c == dropAt) dropValid(port);
            if ((port != 1 && req0_done) || (port != 0 && req1_done)) begin
                k   = c;
                who = req0_done ? 0 : 1;
                if (dropAt == -1) dropValid(port);
                break;
            end
        end
    endtask

    task automatic applyStimulusIdle();
        req0_valid = 0; req0_we = 0; req0_addr = '0; req0_wdata = '0;
        req1_valid = 0; req1_we = 0; req1_addr = '0; req1_wdata = '0;
    endtask

    task automatic test_reset();
        applyStimulusIdle();
        Reset = 1'b1;
        #5;
        testsRun++;
        if ({SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_LB_N, SRAM_UB_N} !== 5'b11111) begin
            testsFailed++;
            $display("[TB] FAIL reset_strobes got %b expected 11111",
                     {SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_LB_N, SRAM_UB_N});
        end
        testsRun++;
        if ({dq_oe, req0_done, req1_done} !== 3'b000) begin
            testsFailed++;
            $display("[TB] FAIL reset_ctrl got %b expected 000", {dq_oe, req0_done, req1_done});
        end
        testsRun++;
        if (rdata !== 16'h0 || SRAM_ADDR !== 20'h0 || dq_out !== 16'h0) begin
            testsFailed++;
            $display("[TB] FAIL reset_data got rdata=%h addr=%h dq_out=%h expected zeros", rdata, SRAM_ADDR, dq_out);
        end
        @(posedge Clk); @(posedge Clk); #1;
        Reset = 1'b0;
    endtask

    task automatic test_single_read();
        int k, who;
        logic [31:0] ceT, oeT, weT, dqT, ceExp, oeExp;
        mem[20'h00123] = 16'hBEEF;
        issue(0, 1'b0, 20'h00123, 16'h0000, 1'b1);
        waitDone(0, -1, k, who, ceT, oeT, weT, dqT);
        ceExp = '0; oeExp = '0;
        for (int c = 1; c <= W + 2; c++) ceExp[c] = 1'b1;
        for (int c = 2; c <= W + 1; c++) oeExp[c] = 1'b1;
        testsRun++;
        if (k != W + 2) begin
            testsFailed++;
            $display("[TB] FAIL read_latency got %0d expected %0d", k, W + 2);
        end
        testsRun++;
        if (ceT !== ceExp || oeT !== oeExp) begin
            testsFailed++;
            $display("[TB] FAIL read_strobes got ce=%h oe=%h expected ce=%h oe=%h", ceT, oeT, ceExp, oeExp);
        end
        testsRun++;
        if (weT !== 32'h0 || dqT !== 32'h0) begin
            testsFailed++;
            $display("[TB] FAIL read_no_drive got we=%h dq_oe=%h expected 0", weT, dqT);
        end
        testsRun++;
        if (rdata !== 16'hBEEF) begin
            testsFailed++;
            $display("[TB] FAIL read_rdata got %h expected BEEF", rdata);
        end
    endtask

    task automatic test_single_write();
        int k, who;
        logic [31:0] ceT, oeT, weT, dqT, weExp, dqExp;
        issue(1, 1'b1, 20'h00040, 16'h5A5A, 1'b1);
        waitDone(1, -1, k, who, ceT, oeT, weT, dqT);
        weExp = '0; dqExp = '0;
        for (int c = 2; c <= W + 1; c++) weExp[c] = 1'b1;
        for (int c = 1; c <= W + 2; c++) dqExp[c] = 1'b1;
        testsRun++;
        if (k != W + 2 || who != 1) begin
            testsFailed++;
            $display("[TB] FAIL write_latency got k=%0d port=%0d expected k=%0d port=1", k, who, W + 2);
        end
        testsRun++;
        if (weT !== weExp || dqT !== dqExp || oeT !== 32'h0) begin
            testsFailed++;
            $display("[TB] FAIL write_strobes got we=%h dq=%h oe=%h expected we=%h dq=%h oe=0",
                     weT, dqT, oeT, weExp, dqExp);
        end
        testsRun++;
        if (memRead(20'h00040) !== 16'h5A5A) begin
            testsFailed++;
            $display("[TB] FAIL write_mem got %h expected 5A5A", memRead(20'h00040));
        end
        @(negedge Clk);
        testsRun++;
        if (req1_done !== 1'b0 || dq_oe !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL write_done_pulse got done=%b dq_oe=%b expected 0 0", req1_done, dq_oe);
        end
        testsRun++;
        if (rdata !== 16'hBEEF) begin
            testsFailed++;
            $display("[TB] FAIL rdata_hold got %h expected BEEF", rdata);
        end
    endtask

    task automatic test_reset_mid_write();
        int k, who, doneSeen;
        logic [31:0] ceT, oeT, weT, dqT;
        issue(1, 1'b1, 20'h00077, 16'h1234, 1'b0);
        @(negedge Clk); @(negedge Clk); @(negedge Clk);
        testsRun++;
        if (SRAM_WE_N !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL midreset_in_access got WE_N=%b expected 0", SRAM_WE_N);
        end
        #2 Reset = 1'b1;
        #1;
        testsRun++;
        if ({SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_LB_N, SRAM_UB_N, dq_oe} !== 6'b111110) begin
            testsFailed++;
            $display("[TB] FAIL midreset_async got %b expected 111110",
                     {SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_LB_N, SRAM_UB_N, dq_oe});
        end
        dropValid(1);
        doneSeen = 0;
        for (int c = 0; c < 2; c++) begin
            @(negedge Clk);
            if (req0_done || req1_done) doneSeen++;
        end
        @(posedge Clk); #1;
        Reset = 1'b0;
        for (int c = 0; c < W + 3; c++) begin
            @(negedge Clk);
            if (req0_done || req1_done) doneSeen++;
        end
        testsRun++;
        if (doneSeen != 0) begin
            testsFailed++;
            $display("[TB] FAIL midreset_no_done got %0d done pulses expected 0", doneSeen);
        end
        mem[20'h00456] = 16'hCAFE;
        issue(0, 1'b0, 20'h00456, 16'h0000, 1'b1);
        waitDone(0, -1, k, who, ceT, oeT, weT, dqT);
        testsRun++;
        if (k != W + 2 || rdata !== 16'hCAFE) begin
            testsFailed++;
            $display("[TB] FAIL postreset_read got k=%0d rdata=%h expected k=%0d rdata=CAFE", k, rdata, W + 2);
        end
    endtask

    task automatic test_valid_dropped();
        int k, who, ceSeen;
        logic [31:0] ceT, oeT, weT, dqT;
        mem[20'h00500] = 16'h0BAD;
        issue(0, 1'b0, 20'h00500, 16'h0000, 1'b1);
        waitDone(0, 1, k, who, ceT, oeT, weT, dqT);
        testsRun++;
        if (k != W + 2) begin
            testsFailed++;
            $display("[TB] FAIL dropped_latency got %0d expected %0d", k, W + 2);
        end
        ceSeen = 0;
        for (int c = 0; c < W + 4; c++) begin
            @(negedge Clk);
            if (!SRAM_CE_N) ceSeen++;
        end
        testsRun++;
        if (ceSeen != 0) begin
            testsFailed++;
            $display("[TB] FAIL dropped_no_regrant got %0d active cycles expected 0", ceSeen);
        end
    endtask

    task automatic test_back_to_back();
        int k, who, port1Count, ceSeen;
        int order[4];
        exp_t e;
        logic [31:0] ceT, oeT, weT, dqT;
`ifdef ARB_ROUND_ROBIN_EN
        order = '{0, 1, 0, 1};
`else
        order = '{0, 0, 0, 0};
`endif
        @(posedge Clk); #1 Reset = 1'b1;
        @(posedge Clk); #1 Reset = 1'b0;
        mem[20'h00200] = 16'h1111;
        mem[20'h00300] = 16'h2222;
        @(posedge Clk); #1;
        req0_we = 0; req0_addr = 20'h00200; req0_valid = 1'b1;
        req1_we = 0; req1_addr = 20'h00300; req1_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            e.port = order[i]; e.we = 1'b0;
            e.addr = order[i] ? 20'h00300 : 20'h00200;
            e.data = order[i] ? 16'h2222 : 16'h1111;
            sbQ.push_back(e);
        end
        port1Count = 0;
        for (int i = 0; i < 4; i++) begin
            waitDone(2, -2, k, who, ceT, oeT, weT, dqT);
            if (i == 3) begin
                req0_valid = 1'b0; req1_valid = 1'b0;
            end
            if (who == 1) port1Count++;
            testsRun++;
            if (who != order[i] || k != W + 2) begin
                testsFailed++;
                $display("[TB] FAIL grant_order[%0d] got port=%0d k=%0d expected port=%0d k=%0d",
                         i, who, k, order[i], W + 2);
            end
        end
        testsRun++;
        if (port1Count != order[1] + order[3]) begin
            testsFailed++;
            $display("[TB] FAIL port1_grants got %0d expected %0d", port1Count, order[1] + order[3]);
        end
        ceSeen = 0;
        for (int c = 0; c < W + 4; c++) begin
            @(negedge Clk);
            if (!SRAM_CE_N) ceSeen++;
        end
        testsRun++;
        if (ceSeen != 0) begin
            testsFailed++;
            $display("[TB] FAIL contention_idle got %0d active cycles expected 0", ceSeen);
        end
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_single_read();
        test_single_write();
        test_reset_mid_write();
        test_valid_dropped();
        test_back_to_back();
        testsRun++;
        if (sbQ.size() != 0) begin
            testsFailed++;
            $display("[TB] FAIL sb_drain got %0d pending expected 0", sbQ.size());
        end
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
